// File: rtl/game_timer_if.sv
// Command/status bundle between the game-control FSM and game_timer.
//   master : game-control side; drives start/pause/stop/clear pulses and
//            reads timer/running/sec_tick/time_up (and minutes/seconds
//            when GAME_TIMER_MMSS_EN is defined).
//   slave  : game_timer side.
interface game_timer_if;
  logic        start;
  logic        pause;
  logic        stop;
  logic        clear;
  logic [10:0] timer;
  logic        running;
  logic        sec_tick;
  logic        time_up;
`ifdef GAME_TIMER_MMSS_EN
  logic [5:0]  minutes;
  logic [5:0]  seconds;
`endif

  modport master (
    output start, pause, stop, clear,
`ifdef GAME_TIMER_MMSS_EN
    input  minutes, seconds,
`endif
    input  timer, running, sec_tick, time_up
  );

  modport slave (
    input  start, pause, stop, clear,
`ifdef GAME_TIMER_MMSS_EN
    output minutes, seconds,
`endif
    output timer, running, sec_tick, time_up
  );
endinterface

// File: rtl/game_timer.sv
// Elapsed-time generator for a sudoku round.
// Divides clk to 1 s ticks, counts them while RUNNING, freezes on stop.
// Ports:
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   bus      : game_timer_if.slave
//              in  start/pause/stop/clear one-cycle command pulses
//              out timer[10:0] elapsed seconds, running, sec_tick, time_up
// Optional: define GAME_TIMER_MMSS_EN to add registered minutes/seconds
// display outputs kept in step with timer.
module game_timer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TIME_LIMIT = 120,
  parameter int MAX_TIME   = 2047
) (
  input  logic         clk,
  input  logic         reset,
  game_timer_if.slave  bus
);

  localparam int             PW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(CLK_FREQ - 1);
  localparam logic [10:0]    T_MAX   = 11'(MAX_TIME);
  localparam logic [10:0]    T_LIM   = 11'(TIME_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    STOPPED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [10:0]   timer_q, timer_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          time_up_q, time_up_d;
`ifdef GAME_TIMER_MMSS_EN
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
`endif

  // Only the highest-priority command that is legal in the current state acts.
  logic do_clear_s, do_stop_s, do_start_s, do_pause_s, wrap_s, inc_s;
  assign do_clear_s = bus.clear;
  assign do_stop_s  = !do_clear_s && bus.stop &&
                      ((state_q == RUNNING) || (state_q == PAUSED));
  assign do_start_s = !do_clear_s && !do_stop_s && bus.start &&
                      ((state_q == IDLE) || (state_q == STOPPED));
  assign do_pause_s = !do_clear_s && !do_stop_s && !do_start_s && bus.pause &&
                      ((state_q == RUNNING) || (state_q == PAUSED));
  // A wrap coinciding with stop/pause/clear is discarded.
  assign wrap_s     = (state_q == RUNNING) && (prescaler_q == PS_LAST) &&
                      !do_clear_s && !do_stop_s && !do_pause_s;
  assign inc_s      = wrap_s && (timer_q < T_MAX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (do_clear_s) begin
      state_d = IDLE;
    end else if (do_stop_s) begin
      state_d = STOPPED;
    end else if (do_start_s) begin
      state_d = RUNNING;
    end else if (do_pause_s) begin
      case (state_q)
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output next values.
  always_comb begin
    prescaler_d = prescaler_q;
    timer_d     = timer_q;
    tick_d      = 1'b0;
    time_up_d   = time_up_q;
    running_d   = (state_d == RUNNING);
`ifdef GAME_TIMER_MMSS_EN
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
`endif
    if (do_clear_s || do_start_s) begin
      prescaler_d = '0;
      timer_d     = 11'd0;
      time_up_d   = 1'b0;
`ifdef GAME_TIMER_MMSS_EN
      minutes_d   = 6'd0;
      seconds_d   = 6'd0;
`endif
    end else if (wrap_s) begin
      prescaler_d = '0;
      tick_d      = 1'b1;
      if (inc_s) begin
        timer_d   = timer_q + 11'd1;
        // Compare against the new value so the flag lands on the same edge.
        time_up_d = ((timer_q + 11'd1) >= T_LIM);
`ifdef GAME_TIMER_MMSS_EN
        if (seconds_q == 6'd59) begin
          seconds_d = 6'd0;
          minutes_d = minutes_q + 6'd1;
        end else begin
          seconds_d = seconds_q + 6'd1;
        end
`endif
      end else begin
        timer_d = timer_q;
      end
    end else if ((state_q == RUNNING) && !do_stop_s && !do_pause_s) begin
      prescaler_d = prescaler_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      // PAUSED/STOPPED/IDLE, or a pause/stop edge: everything holds.
      prescaler_d = prescaler_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      timer_q     <= 11'd0;
      running_q   <= 1'b0;
      tick_q      <= 1'b0;
      time_up_q   <= 1'b0;
`ifdef GAME_TIMER_MMSS_EN
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
`endif
    end else begin
      prescaler_q <= prescaler_d;
      timer_q     <= timer_d;
      running_q   <= running_d;
      tick_q      <= tick_d;
      time_up_q   <= time_up_d;
`ifdef GAME_TIMER_MMSS_EN
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
`endif
    end
  end

  assign bus.timer    = timer_q;
  assign bus.running  = running_q;
  assign bus.sec_tick = tick_q;
  assign bus.time_up  = time_up_q;
`ifdef GAME_TIMER_MMSS_EN
  assign bus.minutes  = minutes_q;
  assign bus.seconds  = seconds_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_timer_if bus();
  game_timer #(.CLK_FREQ(4), .TIME_LIMIT(5), .MAX_TIME(7)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

`ifdef GAME_TIMER_MMSS_EN
  game_timer_if mbus();
  game_timer #(.CLK_FREQ(2), .TIME_LIMIT(100), .MAX_TIME(2047)) mdut (
    .clk(clk), .reset(reset), .bus(mbus)
  );
  typedef struct { int e; logic [10:0] timer; logic [5:0] mins; logic [5:0] secs; } mm_t;
  mm_t mq[$];
  mm_t m;
`endif

  typedef struct { int e; logic [10:0] timer; logic run; logic tick; logic tu; } snap_t;
  typedef struct { int e; logic [10:0] timer; logic tu; } tick_t;
  snap_t sq[$];
  snap_t aq[$];
  tick_t tq[$];
  snap_t s;
  tick_t t;

  int   edge_n  = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  logic done    = 1'b0;
  logic chk_req = 1'b0;
  int   S, S2, S3, S4, M;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void exp_snap(int e, logic [10:0] tm, logic r, logic k, logic u);
    snap_t x;
    x.e = e; x.timer = tm; x.run = r; x.tick = k; x.tu = u;
    sq.push_back(x);
  endfunction

  function automatic void exp_tick(int e, logic [10:0] tm, logic u);
    tick_t x;
    x.e = e; x.timer = tm; x.tu = u;
    tq.push_back(x);
  endfunction

  task automatic wait_edge(int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic cmd(logic st, logic pa, logic sp, logic cl);
    bus.start = st; bus.pause = pa; bus.stop = sp; bus.clear = cl;
    @(negedge clk);
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk or posedge chk_req) begin
    if (aq.size() > 0) begin
      while (aq.size() > 0) begin
        s = aq.pop_front();
        n_vec++;
        if (bus.timer !== s.timer || bus.running !== s.run ||
            bus.sec_tick !== s.tick || bus.time_up !== s.tu) begin
          n_err++;
          $display("FAIL async_reset: got timer=%0d run=%b tick=%b tu=%b, want timer=%0d run=%b tick=%b tu=%b",
                   bus.timer, bus.running, bus.sec_tick, bus.time_up, s.timer, s.run, s.tick, s.tu);
        end
      end
    end else begin
      while (sq.size() > 0 && sq[0].e <= edge_n) begin
        s = sq.pop_front();
        n_vec++;
        if (s.e != edge_n || bus.timer !== s.timer || bus.running !== s.run ||
            bus.sec_tick !== s.tick || bus.time_up !== s.tu) begin
          n_err++;
          $display("FAIL snap@%0d (now %0d): got timer=%0d run=%b tick=%b tu=%b, want timer=%0d run=%b tick=%b tu=%b",
                   s.e, edge_n, bus.timer, bus.running, bus.sec_tick, bus.time_up, s.timer, s.run, s.tick, s.tu);
        end
      end
      if (bus.sec_tick === 1'b1) begin
        n_vec++;
        if (tq.size() == 0) begin
          n_err++;
          $display("FAIL tick: unexpected sec_tick at edge %0d timer=%0d, want no tick", edge_n, bus.timer);
        end else begin
          t = tq.pop_front();
          if (t.e != edge_n || bus.timer !== t.timer || bus.time_up !== t.tu) begin
            n_err++;
            $display("FAIL tick: got edge=%0d timer=%0d tu=%b, want edge=%0d timer=%0d tu=%b",
                     edge_n, bus.timer, bus.time_up, t.e, t.timer, t.tu);
          end
        end
      end
`ifdef GAME_TIMER_MMSS_EN
      while (mq.size() > 0 && mq[0].e <= edge_n) begin
        m = mq.pop_front();
        n_vec++;
        if (m.e != edge_n || mbus.timer !== m.timer || mbus.minutes !== m.mins ||
            mbus.seconds !== m.secs) begin
          n_err++;
          $display("FAIL mmss@%0d: got timer=%0d min=%0d sec=%0d, want timer=%0d min=%0d sec=%0d",
                   m.e, mbus.timer, mbus.minutes, mbus.seconds, m.timer, m.mins, m.secs);
        end
      end
`endif
      if (done || edge_n > 20000) begin
        n_vec++;
        if (!done || sq.size() != 0 || tq.size() != 0) begin
          n_err++;
          $display("FAIL drain: got done=%b pending snaps=%0d ticks=%0d, want done=1 and 0 pending",
                   done, sq.size(), tq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
`ifdef GAME_TIMER_MMSS_EN
    mbus.start = 1'b0; mbus.pause = 1'b0; mbus.stop = 1'b0; mbus.clear = 1'b0;
`endif
    exp_snap(2, 11'd0, 1'b0, 1'b0, 1'b0);
    wait_edge(3);
    reset = 1'b0;

    // Basic counting, pause mid-second, time_up, saturation.
    wait_edge(5);
    S = edge_n + 1;
    exp_snap(S, 11'd0, 1'b1, 1'b0, 1'b0);
    exp_tick(S + 4, 11'd1, 1'b0);
    exp_snap(S + 5, 11'd1, 1'b1, 1'b0, 1'b0);
    exp_tick(S + 8, 11'd2, 1'b0);
    exp_tick(S + 12, 11'd3, 1'b0);
    exp_tick(S + 16, 11'd4, 1'b0);
    exp_snap(S + 19, 11'd4, 1'b0, 1'b0, 1'b0);
    exp_snap(S + 28, 11'd4, 1'b0, 1'b0, 1'b0);
    exp_snap(S + 29, 11'd4, 1'b1, 1'b0, 1'b0);
    exp_tick(S + 31, 11'd5, 1'b1);
    exp_tick(S + 35, 11'd6, 1'b1);
    exp_tick(S + 39, 11'd7, 1'b1);
    exp_tick(S + 43, 11'd7, 1'b1);
    exp_tick(S + 47, 11'd7, 1'b1);
    exp_snap(S + 48, 11'd7, 1'b1, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_edge(S + 18);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    wait_edge(S + 28);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    wait_edge(S + 48);
    exp_snap(S + 49, 11'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);

    // Stop on a wrap cycle, pause ignored when stopped, restart.
    wait_edge(S + 50);
    S2 = edge_n + 1;
    exp_snap(S2, 11'd0, 1'b1, 1'b0, 1'b0);
    exp_tick(S2 + 4, 11'd1, 1'b0);
    exp_tick(S2 + 8, 11'd2, 1'b0);
    exp_snap(S2 + 12, 11'd2, 1'b0, 1'b0, 1'b0);
    exp_snap(S2 + 16, 11'd2, 1'b0, 1'b0, 1'b0);
    exp_snap(S2 + 17, 11'd0, 1'b1, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_edge(S2 + 11);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    wait_edge(S2 + 14);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    wait_edge(S2 + 16);
    S3 = S2 + 17;
    exp_tick(S3 + 4, 11'd1, 1'b0);
    exp_tick(S3 + 8, 11'd2, 1'b0);
    exp_tick(S3 + 12, 11'd3, 1'b0);
    exp_snap(S3 + 14, 11'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);

    // start while RUNNING is ignored; then clear beats stop and start.
    wait_edge(S3 + 6);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_edge(S3 + 13);
    cmd(1'b1, 1'b0, 1'b1, 1'b1);

    // start beats pause from IDLE, then async reset mid-second.
    wait_edge(S3 + 15);
    S4 = edge_n + 1;
    exp_snap(S4, 11'd0, 1'b1, 1'b0, 1'b0);
    exp_tick(S4 + 4, 11'd1, 1'b0);
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    wait_edge(S4 + 6);
    #2;
    reset = 1'b1;
    #1;
    s.e = edge_n; s.timer = 11'd0; s.run = 1'b0; s.tick = 1'b0; s.tu = 1'b0;
    aq.push_back(s);
    chk_req = 1'b1;
    wait_edge(S4 + 8);
    chk_req = 1'b0;
    reset = 1'b0;

`ifdef GAME_TIMER_MMSS_EN
    wait_edge(S4 + 10);
    M = edge_n + 1;
    m.e = M + 120;  m.timer = 11'd60;   m.mins = 6'd1;  m.secs = 6'd0; mq.push_back(m);
    m.e = M + 122;  m.timer = 11'd61;   m.mins = 6'd1;  m.secs = 6'd1; mq.push_back(m);
    m.e = M + 4094; m.timer = 11'd2047; m.mins = 6'd34; m.secs = 6'd7; mq.push_back(m);
    m.e = M + 4110; m.timer = 11'd2047; m.mins = 6'd34; m.secs = 6'd7; mq.push_back(m);
    mbus.start = 1'b1;
    @(negedge clk);
    mbus.start = 1'b0;
    wait_edge(M + 4111);
`endif

    wait_edge(edge_n + 2);
    done = 1'b1;
  end

endmodule
